dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_byte_lane.sv | 39 +++
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the store byte-lane mask helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte enables for an access of the given size at the (already aligned) lane offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: lane_mask = 4'b0001 << lo;
            F3_H, F3_HU: lane_mask = 4'b0011 << {lo[1], 1'b0};
            F3_W:        lane_mask = 4'b1111;
            default:     lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational lane steering: store byte-enables and replicated write data,
// load lane extraction with sign/zero extension.
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be = lane_mask(i_funct3, i_addr_lo);

        // Replicating the source across lanes lets the byte enables pick the target lane.
        case (i_funct3[1:0])
            2'b00:   o_wdata = {4{i_wdata[7:0]}};
            2'b01:   o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase

        case (i_funct3)
            F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_rdata = {24'h0, w_shifted[7:0]};
            F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_rdata = {16'h0, w_shifted[15:0]};
            F3_W:    o_rdata = w_shifted;
            default: o_rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store with LATENCY wait states.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic        r_err;
    logic        r_ld_ok;
    logic [31:0] r_rword;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_idle;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_funct3;
    logic        w_write;
    logic [31:0] w_off;
    logic        w_range_err;
    logic        w_bad_f3;
    logic        w_misalign;
    logic [1:0]  w_lo;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic        w_commit;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wsh;
    logic [31:0] w_ld;

    // With zero latency the commit edge is the accept edge, so the live request is used.
    assign w_idle   = (r_state == IDLE);
    assign w_addr   = w_idle ? i_req_addr   : r_addr;
    assign w_wdata  = w_idle ? i_req_wdata  : r_wdata;
    assign w_funct3 = w_idle ? i_req_funct3 : r_funct3;
    assign w_write  = w_idle ? i_req_write  : r_write;

    assign w_off       = w_addr - BASE_ADDR;
    assign w_range_err = ({1'b0, w_off} >= SPAN);
    assign w_idx       = w_off[AW+1:2];

    always_comb begin
        case (w_funct3)
            F3_B, F3_H, F3_W: w_bad_f3 = 1'b0;
            F3_BU, F3_HU:     w_bad_f3 = w_write;
            default:          w_bad_f3 = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_lo       = w_addr[1:0];
    assign w_misalign = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                        ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
    always_comb begin
        case (w_funct3[1:0])
            2'b01:   w_lo = {w_addr[1], 1'b0};
            2'b10:   w_lo = 2'b00;
            default: w_lo = w_addr[1:0];
        endcase
    end
`endif

    assign w_err    = w_range_err | w_bad_f3 | w_misalign;
    assign w_commit = (w_idle && i_req_valid && ZERO_LAT) ||
                      ((r_state == WAIT) && (r_cnt == LAT_LAST));
    assign w_we     = w_commit && w_write && !w_err;

    dmem_byte_lane u_lane (
        .i_funct3  (w_funct3),
        .i_addr_lo (w_lo),
        .i_wdata   (w_wdata),
        .i_rword   (r_rword),
        .o_be      (w_be),
        .o_wdata   (w_wsh),
        .o_rdata   (w_ld)
    );

    // RAM is not reset; write and read sample together on the commit edge.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_rword <= r_mem[w_idx];
            if (w_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_funct3     <= 3'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_ld_ok      <= 1'b0;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_funct3    <= i_req_funct3;
                        r_write     <= i_req_write;
                        r_cnt       <= 4'd0;
                        o_req_ready <= 1'b0;
                        if (ZERO_LAT) begin
                            r_state      <= RESP;
                            o_resp_valid <= 1'b1;
                            r_err        <= w_err;
                            r_ld_ok      <= !w_err && !i_req_write;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_state      <= RESP;
                        o_resp_valid <= 1'b1;
                        r_err        <= w_err;
                        r_ld_ok      <= !w_err && !r_write;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= IDLE;
                        o_resp_valid <= 1'b0;
                        r_err        <= 1'b0;
                        r_ld_ok      <= 1'b0;
                        o_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Captured fields are frozen in RESP, so the extracted load stays stable while held.
    assign o_resp_rdata = r_ld_ok ? w_ld : 32'h0;
    assign o_resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at issue
// and compared at the response handshake.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [2:0]  i_req_funct3 = 3'b0;
    logic [31:0] i_req_wdata = 32'h0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_write  (i_req_write),
        .i_req_addr   (i_req_addr),
        .i_req_funct3 (i_req_funct3),
        .i_req_wdata  (i_req_wdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_junk();
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_addr   = 32'h10;
        i_req_funct3 = F3_W;
        i_req_wdata  = $urandom;
    endtask

    task automatic idle_req();
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
    endtask

    task automatic xact(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int hold);
        int   n;
        exp_t e;
        exp_q.push_back('{rd: exp_rd, err: exp_err});
        @(negedge clk);
        chk({tag, ".req_ready"}, {31'h0, o_req_ready}, 32'h1);
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_addr   = addr;
        i_req_funct3 = f3;
        i_req_wdata  = wd;
        @(posedge clk);
        #1;
        drive_junk();
        n = 1;
        while (!o_resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, n, LAT + 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_rdata"}, o_resp_rdata, exp_q[0].rd);
            chk({tag, ".hold_ready"}, {31'h0, o_req_ready}, 32'h0);
        end
        @(negedge clk);
        idle_req();
        i_resp_ready = 1'b1;
        e = exp_q.pop_front();
        chk({tag, ".rdata"}, o_resp_rdata, e.rd);
        chk({tag, ".err"}, {31'h0, o_resp_err}, {31'h0, e.err});
        @(posedge clk);
        #1;
        i_resp_ready = 1'b0;
        chk({tag, ".valid_drop"}, {31'h0, o_resp_valid}, 32'h0);
        $display("xact %s wr=%0d addr=%h f3=%0d wd=%h -> rdata=%h err=%0d", tag, wr, addr, f3, wd,
                 e.rd, e.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", {31'h0, o_req_ready}, 32'h1);
        chk("rst.resp_valid", {31'h0, o_resp_valid}, 32'h0);
        chk("rst.rdata", o_resp_rdata, 32'h0);
        chk("rst.err", {31'h0, o_resp_err}, 32'h0);
        reset_n = 1'b1;

        xact("sw10",  1, 32'h10, F3_W,  32'hDEADBEEF, 32'h0,        0, 0);
        xact("lw10",  0, 32'h10, F3_W,  32'h0,        32'hDEADBEEF, 0, 0);

        xact("sb11",  1, 32'h11, F3_B,  32'h00000080, 32'h0,        0, 0);
        xact("lb11",  0, 32'h11, F3_B,  32'h0,        32'hFFFFFF80, 0, 0);
        xact("lbu11", 0, 32'h11, F3_BU, 32'h0,        32'h00000080, 0, 0);
        xact("lw10b", 0, 32'h10, F3_W,  32'h0,        32'hDEAD80EF, 0, 0);

        xact("lh12",  0, 32'h12, F3_H,  32'h0,        32'hFFFFDEAD, 0, 5);
        xact("lhu12", 0, 32'h12, F3_HU, 32'h0,        32'h0000DEAD, 0, 0);

        xact("sw30",  1, 32'h30, F3_W,  32'hAABBCCDD, 32'h0,        0, 0);
        xact("sh32",  1, 32'h32, F3_H,  32'h00009876, 32'h0,        0, 0);
        xact("lw30",  0, 32'h30, F3_W,  32'h0,        32'h9876CCDD, 0, 0);
        xact("lh30",  0, 32'h30, F3_H,  32'h0,        32'hFFFFCCDD, 0, 0);

        xact("sw00",  1, 32'h0,    F3_W, 32'h11111111, 32'h0,        0, 0);
        xact("lwoor", 0, 32'h1000, F3_W, 32'h0,        32'h0,        1, 0);
        xact("swoor", 1, 32'h1000, F3_W, 32'h55555555, 32'h0,        1, 0);
        xact("lw00",  0, 32'h0,    F3_W, 32'h0,        32'h11111111, 0, 0);
        xact("lw10c", 0, 32'h10,   F3_W, 32'h0,        32'hDEAD80EF, 0, 0);

        xact("ldbad", 0, 32'h10, 3'b011, 32'h0,        32'h0,        1, 0);
        xact("stbad", 1, 32'h10, 3'b011, 32'h77777777, 32'h0,        1, 0);
        xact("lw10d", 0, 32'h10, F3_W,   32'h0,        32'hDEAD80EF, 0, 0);

`ifdef DMEM_MISALIGN_ERR_EN
        xact("lw11",  0, 32'h11, F3_W, 32'h0,        32'h0,        1, 0);
        xact("lh13",  0, 32'h13, F3_H, 32'h0,        32'h0,        1, 0);
        xact("sw31",  1, 32'h31, F3_W, 32'h01020304, 32'h0,        1, 0);
        xact("lw30b", 0, 32'h30, F3_W, 32'h0,        32'h9876CCDD, 0, 0);
`else
        xact("lw11",  0, 32'h11, F3_W, 32'h0,        32'hDEAD80EF, 0, 0);
        xact("lh13",  0, 32'h13, F3_H, 32'h0,        32'hFFFFDEAD, 0, 0);
        xact("sw31",  1, 32'h31, F3_W, 32'h01020304, 32'h0,        0, 0);
        xact("lw30b", 0, 32'h30, F3_W, 32'h0,        32'h01020304, 0, 0);
`endif

        xact("sw20",  1, 32'h20, F3_W, 32'hCAFEF00D, 32'h0, 0, 0);
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_addr   = 32'h20;
        i_req_funct3 = F3_W;
        i_req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        idle_req();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst.req_ready", {31'h0, o_req_ready}, 32'h1);
        chk("midrst.resp_valid", {31'h0, o_resp_valid}, 32'h0);
        chk("midrst.rdata", o_resp_rdata, 32'h0);
        chk("midrst.err", {31'h0, o_resp_err}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("xact midrst: reset asserted during WAIT of SW @00000020");
        xact("lw20",  0, 32'h20, F3_W, 32'h0, 32'hCAFEF00D, 0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
